alu_seq: RTL

- Parametrised, handshaked successor to the single-cycle integer ALU in the RV32I execute stage.
- Adds the missing SLL/SRL/SRA using an iterative shifter, plus valid/ready flow control on both sides.
- Sits between decode/operand-fetch (upstream) and writeback (downstream).
- Non-shift ops complete in one cycle; shifts take a variable number of cycles.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_shift_unit.sv | 78 +++++++
 rtl/alu_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and helper definitions for the sequential RV32I ALU.
// Used by alu_seq and alu_shift_unit (see ALU_FAST_SHIFT_EN in those files).
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shift engine for alu_seq: iterative by default, combinational barrel shifter
// when ALU_FAST_SHIFT_EN is defined.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
`ifndef ALU_FAST_SHIFT_EN
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     done,
`endif
  input  logic [3:0]               op,
  input  logic [XLEN-1:0]          data,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic [XLEN-1:0]          result
);

`ifdef ALU_FAST_SHIFT_EN

  always_comb begin
    result = '0;
    case (op)
      OP_SLL:  result = data << shamt;
      OP_SRL:  result = data >> shamt;
      OP_SRA:  result = $signed(data) >>> shamt;
      default: result = '0;
    endcase
  end

`else

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_next;
  logic [SW-1:0]   remaining_q;
  logic [SW-1:0]   step;
  logic            left_q;
  logic            arith_q;

  // The final partial step is clipped to whatever distance is still left.
  always_comb begin
    step = (remaining_q < STEP) ? remaining_q : STEP;
    if (left_q)
      data_next = data_q << step;
    else if (arith_q)
      data_next = $signed(data_q) >>> step;
    else
      data_next = data_q >> step;
  end

  assign result = data_next;
  assign done   = (remaining_q != '0) && (remaining_q <= STEP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      remaining_q <= '0;
      left_q      <= 1'b0;
      arith_q     <= 1'b0;
    end else if (start) begin
      data_q      <= data;
      remaining_q <= shamt;
      left_q      <= (op == OP_SLL);
      arith_q     <= (op == OP_SRA);
    end else if (remaining_q != '0) begin
      data_q      <= data_next;
      remaining_q <= remaining_q - step;
    end
  end

`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked RV32I ALU with iterative shifts; define ALU_FAST_SHIFT_EN to make
// every op, shifts included, complete with latency 1 via a barrel shifter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [3:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd
);

  localparam int SW = $clog2(XLEN);

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] rd_q;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] shift_result;
  logic [SW-1:0]   shamt;
  logic            accept;
  logic            shift_start;
  logic            shift_done;

  assign shamt     = rs2[SW-1:0];
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign rd        = rd_q;

`ifdef ALU_FAST_SHIFT_EN
  assign shift_start = 1'b0;
  assign shift_done  = 1'b0;

  alu_shift_unit #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shift (
    .op     (op),
    .data   (rs1),
    .shamt  (shamt),
    .result (shift_result)
  );
`else
  // A zero-distance shift is just a copy of rs1, so it skips the SHIFT state.
  assign shift_start = accept && is_shift(op) && (shamt != '0);

  alu_shift_unit #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (shift_start),
    .done   (shift_done),
    .op     (op),
    .data   (rs1),
    .shamt  (shamt),
    .result (shift_result)
  );
`endif

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = rs1 + rs2;
      OP_SUB:  alu_result = rs1 - rs2;
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      OP_XOR:  alu_result = rs1 ^ rs2;
      OP_OR:   alu_result = rs1 | rs2;
      OP_AND:  alu_result = rs1 & rs2;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: alu_result = shift_result;
`else
      OP_SLL, OP_SRL, OP_SRA: alu_result = rs1;
`endif
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)     state_d = shift_start ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (shift_done) state_d = ST_DONE;
      ST_DONE:  if (out_ready)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !shift_start)
        rd_q <= alu_result;
      else if ((state_q == ST_SHIFT) && shift_done)
        rd_q <= shift_result;
    end
  end

endmodule
